// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) onehot_to_idx = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first asserted request after i_last, wrapping mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic [SEL_W-1:0] o_win,
  output logic             o_any
);

  assign o_any = |i_req;

  // Walk from the farthest candidate back to the nearest so the nearest hit overwrites.
  always_comb begin
    o_win = i_last;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[i_last + SEL_W'(k)]) o_win = i_last + SEL_W'(k);
    end
  end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 datapath mux.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module mux_4x1_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_grant,
  output logic [SEL_W-1:0] o_select,
  output logic             o_busy,
  output logic             o_timeout
);

  state_t           r_state, w_state_next;
  logic [N_REQ-1:0] r_grant, w_grant_next;
  logic [SEL_W-1:0] r_select, w_select_next;
  logic [SEL_W-1:0] r_last, w_last_next;
  logic [SEL_W-1:0] w_owner, w_win;
  logic [N_REQ-1:0] w_req_eligible;
  logic             w_any, w_owner_req, w_issue, w_expire;

  assign w_owner     = onehot_to_idx(r_grant);
  assign w_owner_req = i_req[w_owner];

  rr_pick4 u_pick (
    .i_req  (w_req_eligible),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold, w_hold_next;
  logic [N_REQ-1:0]  r_mask, w_mask_next;
  logic              r_timeout, w_timeout_next;

  assign w_req_eligible = i_req & ~r_mask;
  // r_hold counts completed grant cycles, so this edge would make it MAX_HOLD.
  assign w_expire = (r_state == ST_GRANTED) && w_owner_req &&
                    (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    w_hold_next    = r_hold;
    w_mask_next    = r_mask & i_req;
    w_timeout_next = 1'b0;
    if (w_issue) begin
      w_hold_next = '0;
    end else if ((r_state == ST_GRANTED) && w_owner_req && !w_expire) begin
      w_hold_next = r_hold + 1'b1;
    end
    if (w_expire) begin
      w_mask_next[w_owner] = 1'b1;
      w_timeout_next       = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_mask    <= w_mask_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_hold;

  assign w_req_eligible = i_req;
  assign w_expire       = 1'b0;
  assign o_timeout      = 1'b0;
  assign w_unused_hold  = (MAX_HOLD < 1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_select <= '0;
      r_last   <= SEL_W'(N_REQ - 1);
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_select <= w_select_next;
      r_last   <= w_last_next;
    end
  end

  // Leaving GRANTED always passes through IDLE, giving the mandatory turnaround cycle.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_GRANTED;
          w_issue      = 1'b1;
        end
      end
      ST_GRANTED: begin
        if (!w_owner_req || w_expire) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant_next  = r_grant;
    w_select_next = r_select;
    w_last_next   = r_last;
    if (w_issue) begin
      w_grant_next  = N_REQ'(1) << w_win;
      w_select_next = w_win;
      w_last_next   = w_win;
    end else if (w_state_next == ST_IDLE) begin
      w_grant_next = '0;
    end
  end

  assign o_grant  = r_grant;
  assign o_select = r_select;
  assign o_busy   = (r_state == ST_GRANTED);

endmodule
